interleaver_pingpong_ctrl: RTL and testbench
============================================

Name: interleaver_pingpong_ctrl

Overview:
Controller that sequences the bit interleaver's two-bank ping-pong RAM between the FEC encoder (upstream) and the mapper (downstream). Tracks bank ownership, generates the sequential write address k and read index j, and runs the valid/ready handshakes on both sides. The permutation j->mk and the RAM array live in the datapath; this block issues enables, bank selects and counters only. The RAM has 1-cycle synchronous read latency.

Parameters:
Ncbps, 192, coded bits per OFDM symbol (block length); legal 2..256
ADDR_W, 8, counter width; must satisfy 2**ADDR_W >= Ncbps

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
valid_in  in  1  upstream (FEC) bit valid
ready_out  out  1  controller can accept a bit this cycle
wr_en  out  1  RAM write strobe (= valid_in & ready_out)
wr_bank  out  1  bank written when wr_en
wr_addr  out  ADDR_W  write address k, 0..Ncbps-1
rd_en  out  1  RAM read strobe
rd_bank  out  1  bank read when rd_en
rd_index  out  ADDR_W  read index j presented with rd_en (datapath permutes it)
valid_out  out  1  output bit valid (RAM data aligned)
ready_in  in  1  downstream (mapper) ready
data_out_index  out  ADDR_W  index j of the bit currently on the output while valid_out
block_done  out  1  one-cycle pulse when the last bit of a block is handed off downstream
bank_full  out  2  per-bank full flags

Behaviour:
- Reset (resetN=0, async): bank_full=00, wr_bank=0, rd_bank=0, wr_addr=0, rd_index=0, data_out_index=0, valid_out=0, block_done=0; ready_out=1 from the first cycle after release.
- ready_out = !bank_full[wr_bank] (combinational). wr_en = valid_in & ready_out.
- On wr_en: wr_addr increments; at wr_addr==Ncbps-1, bank_full[wr_bank] set, wr_bank toggles, wr_addr returns to 0 (same edge).
- rd_en = bank_full[rd_bank] & (!valid_out | ready_in) (combinational).
- On rd_en: rd_index increments; data_out_index <= rd_index. At rd_index==Ncbps-1, bank_full[rd_bank] cleared, rd_bank toggles, rd_index returns to 0.
- valid_out registered: next = rd_en | (valid_out & !ready_in). Output stage holds while valid_out & !ready_in; data_out_index stable while held.
- block_done pulses on the cycle valid_out & ready_in & data_out_index==Ncbps-1.
- Latency: last write of block N -> rd_en 1 cycle later (bank_full registered) -> valid_out 1 cycle after that. Minimum 2 cycles from final wr_en to first valid_out.
- Steady state with ready_in=1 and continuous valid_in: 1 bit/cycle in and out, no bubbles; ready_out never drops.
- Both banks full: ready_out=0 until the reader clears its bank; the writer may write that bank from the cycle after the clear (flag registered), so no write hits an unread address.
- Set and clear of the same bank in the same cycle is impossible by construction (the writer and reader always own different banks when both are active); an assertion flags it.
- Bank flags are never set or cleared except at block boundaries; partial blocks stay in the writer's bank indefinitely.
- Reset mid-block: all state is discarded, no block_done, and the partial block is lost.

Optional Feature:
INTLV_FLUSH_EN: when defined, adds input port flush (1 bit, synchronous). flush=1 for one cycle aborts the partial write block (wr_addr<-0, wr_bank kept) and the in-progress read (bank_full[rd_bank] cleared, rd_index<-0, valid_out<-0, rd_bank toggled only if the reader was active). flush has priority over simultaneous wr_en/rd_en. When undefined, the port is absent and only resetN clears state.

Test Plan:
- Reset then 192 continuous valid_in, ready_in=1 -> bank_full=01 after bit 191, rd_en cycle 193, first valid_out cycle 194, data_out_index 0..191, block_done on index 191.
- Stream 5 back-to-back blocks, ready_in=1 -> ready_out stays 1, wr_bank/rd_bank alternate 0,1,0,..., exactly 5 block_done pulses, 960 output beats.
- Hold ready_in=0 during 3 full blocks of input -> bank_full=11 after block 2, ready_out=0, third block stalls; releasing ready_in drains bank 0, and ready_out returns the cycle after its flag clears.
- ready_in toggled 1/0 every cycle mid-block -> data_out_index held across stalls, no index skipped or duplicated, 192 beats per block.
- Assert resetN=0 at wr_addr=100 -> all outputs at reset values asynchronously, next block restarts at wr_addr 0 in bank 0.
- (INTLV_FLUSH_EN) flush at wr_addr=50 with reader idle -> wr_addr=0, bank_full unchanged, no block_done.

Source files
------------

// File: rtl/interleaver_pingpong_ctrl_if.sv
// Handshake and RAM-control bundle between the ping-pong controller (master)
// and the interleaver datapath / stream endpoints (slave).
interface interleaver_pingpong_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              valid_in;
    logic              ready_out;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_index;
    logic              valid_out;
    logic              ready_in;
    logic [ADDR_W-1:0] data_out_index;
    logic              block_done;
    logic [1:0]        bank_full;

    modport master (
        input  valid_in,
        input  ready_in,
        output ready_out,
        output wr_en,
        output wr_bank,
        output wr_addr,
        output rd_en,
        output rd_bank,
        output rd_index,
        output valid_out,
        output data_out_index,
        output block_done,
        output bank_full
    );

    modport slave (
        output valid_in,
        output ready_in,
        input  ready_out,
        input  wr_en,
        input  wr_bank,
        input  wr_addr,
        input  rd_en,
        input  rd_bank,
        input  rd_index,
        input  valid_out,
        input  data_out_index,
        input  block_done,
        input  bank_full
    );
endinterface

// File: rtl/interleaver_pingpong_ctrl.sv
// Two-bank ping-pong sequencer for the bit interleaver RAM: bank ownership,
// write address / read index counters and both stream handshakes. Optional abort port: INTLV_FLUSH_EN.
module interleaver_pingpong_ctrl #(
    parameter int Ncbps  = 192,
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic resetN,
`ifdef INTLV_FLUSH_EN
    input  logic flush,
`endif
    interleaver_pingpong_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(Ncbps - 1);

    if (Ncbps < 2 || Ncbps > 256 || (1 << ADDR_W) < Ncbps) begin : g_bad_param
        $error("interleaver_pingpong_ctrl: illegal Ncbps/ADDR_W combination");
    end

    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              valid_out_q, valid_out_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_index_q, rd_index_d;
    logic [ADDR_W-1:0] data_out_index_q, data_out_index_d;

    logic flush_w;
    logic ready_out_w;
    logic wr_en_w, rd_en_w;
    logic wr_last_w, rd_last_w;
    logic reader_active_w;

`ifdef INTLV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign ready_out_w     = !bank_full_q[wr_bank_q];
    assign reader_active_w = bank_full_q[rd_bank_q];
    // An abort suppresses both RAM strobes so nothing lands in a discarded block.
    assign wr_en_w   = bus.valid_in & ready_out_w & !flush_w;
    assign rd_en_w   = reader_active_w & (!valid_out_q | bus.ready_in) & !flush_w;
    assign wr_last_w = wr_en_w && (wr_addr_q == LAST);
    assign rd_last_w = rd_en_w && (rd_index_q == LAST);

    // Flags only move at block boundaries; an abort releases the reader's bank.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic set_w;
        logic clr_w;
        assign set_w = wr_last_w && (wr_bank_q == 1'(gi));
        assign clr_w = (rd_last_w || flush_w) && (rd_bank_q == 1'(gi));
        assign bank_full_d[gi] = (bank_full_q[gi] | set_w) & ~clr_w;
    end

    always_comb begin
        wr_addr_d        = wr_addr_q;
        wr_bank_d        = wr_bank_q;
        rd_index_d       = rd_index_q;
        rd_bank_d        = rd_bank_q;
        data_out_index_d = data_out_index_q;
        valid_out_d      = rd_en_w | (valid_out_q & !bus.ready_in);

        if (flush_w) begin
            wr_addr_d   = '0;
            rd_index_d  = '0;
            rd_bank_d   = rd_bank_q ^ reader_active_w;
            valid_out_d = 1'b0;
        end else begin
            if (wr_en_w) begin
                if (wr_last_w) begin
                    wr_addr_d = '0;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
            if (rd_en_w) begin
                data_out_index_d = rd_index_q;
                if (rd_last_w) begin
                    rd_index_d = '0;
                    rd_bank_d  = ~rd_bank_q;
                end else begin
                    rd_index_d = rd_index_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bank_full_q      <= 2'b00;
            wr_bank_q        <= 1'b0;
            rd_bank_q        <= 1'b0;
            valid_out_q      <= 1'b0;
            wr_addr_q        <= '0;
            rd_index_q       <= '0;
            data_out_index_q <= '0;
        end else begin
            bank_full_q      <= bank_full_d;
            wr_bank_q        <= wr_bank_d;
            rd_bank_q        <= rd_bank_d;
            valid_out_q      <= valid_out_d;
            wr_addr_q        <= wr_addr_d;
            rd_index_q       <= rd_index_d;
            data_out_index_q <= data_out_index_d;
        end
    end

    assign bus.ready_out      = ready_out_w;
    assign bus.wr_en          = wr_en_w;
    assign bus.wr_bank        = wr_bank_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.rd_en          = rd_en_w;
    assign bus.rd_bank        = rd_bank_q;
    assign bus.rd_index       = rd_index_q;
    assign bus.valid_out      = valid_out_q;
    assign bus.data_out_index = data_out_index_q;
    assign bus.bank_full      = bank_full_q;
    assign bus.block_done     = valid_out_q & bus.ready_in & (data_out_index_q == LAST);

    // Writer and reader never own the same bank while both are active.
    a_no_set_clr_same_bank : assert property (@(posedge clk) disable iff (!resetN)
        !(wr_last_w && rd_last_w && (wr_bank_q == rd_bank_q)));

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Scoreboard bench for interleaver_pingpong_ctrl: writers push expected output
// indices per completed block, a negedge monitor pops them on every handshake.
module tb_interleaver_pingpong_ctrl;

    localparam int NC = 192;
    localparam int AW = 8;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
`ifdef INTLV_FLUSH_EN
    logic flush  = 1'b0;
`endif

    always #5 clk = ~clk;

    interleaver_pingpong_ctrl_if #(.ADDR_W(AW)) bus ();

    interleaver_pingpong_ctrl #(.Ncbps(NC), .ADDR_W(AW)) dut (
        .clk    (clk),
        .resetN (resetN),
`ifdef INTLV_FLUSH_EN
        .flush  (flush),
`endif
        .bus    (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   exp_q[$];
    int   beats    = 0;
    int   dones    = 0;
    int   exp_wr_count  = 0;
    logic exp_wr_bank   = 1'b0;
    int   blocks_since_reset = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one comparison set per downstream handshake.
    always @(negedge clk) begin
        int e;
        if (resetN) begin
            if (bus.valid_out && bus.ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_queue_size", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out_index", int'(bus.data_out_index), e);
                    check("block_done_on_beat", int'(bus.block_done), (e == NC - 1) ? 1 : 0);
                    beats++;
                end
            end else if (bus.block_done) begin
                check("stray_block_done", 1, 0);
            end
            if (bus.block_done) begin
                dones++;
                $display("block_done #%0d beats=%0d t=%0t", dones, beats, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic write_bits(input int n, output int stalls);
        int acc;
        int guard;
        acc = 0; guard = 0; stalls = 0;
        bus.valid_in = 1'b1;
        while (acc < n && guard < 4000) begin
            if (bus.ready_out) begin
                check("wr_addr", int'(bus.wr_addr), exp_wr_count % NC);
                check("wr_bank", int'(bus.wr_bank), int'(exp_wr_bank));
                acc++;
                exp_wr_count++;
                if (exp_wr_count % NC == 0) begin
                    for (int i = 0; i < NC; i++) exp_q.push_back(i);
                    exp_wr_bank = ~exp_wr_bank;
                    blocks_since_reset++;
                end
            end else begin
                stalls++;
            end
            guard++;
            step();
        end
        bus.valid_in = 1'b0;
        if (acc < n) check("write_timeout", acc, n);
    endtask

    task automatic drain(input int target);
        int guard;
        guard = 0;
        while (beats < target && guard < 3000) begin
            step();
            guard++;
        end
        check("drain_beats", beats, target);
        step();
        step();
        check("idle_valid_out", int'(bus.valid_out), 0);
        check("idle_bank_full", int'(bus.bank_full), 0);
        check("idle_rd_bank", int'(bus.rd_bank), blocks_since_reset % 2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bank_full"}, int'(bus.bank_full), 0);
        check({tag, "_wr_bank"}, int'(bus.wr_bank), 0);
        check({tag, "_rd_bank"}, int'(bus.rd_bank), 0);
        check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        check({tag, "_rd_index"}, int'(bus.rd_index), 0);
        check({tag, "_data_out_index"}, int'(bus.data_out_index), 0);
        check({tag, "_valid_out"}, int'(bus.valid_out), 0);
        check({tag, "_block_done"}, int'(bus.block_done), 0);
    endtask

    initial begin
        int stalls;
        int stalls4;
        int n;
        int g;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        resetN = 1'b1;
        check("ready_out_after_reset", int'(bus.ready_out), 1);

        // One block, ready_in=1: rd_en the cycle after the last write, valid_out one later
        write_bits(NC, stalls);
        check("t1_bank_full", int'(bus.bank_full), 1);
        check("t1_rd_en", int'(bus.rd_en), 1);
        check("t1_valid_out_pre", int'(bus.valid_out), 0);
        check("t1_wr_bank", int'(bus.wr_bank), 1);
        check("t1_wr_addr", int'(bus.wr_addr), 0);
        step();
        check("t1_valid_out", int'(bus.valid_out), 1);
        check("t1_first_index", int'(bus.data_out_index), 0);
        drain(NC);
        check("t1_dones", dones, 1);

        // Five back-to-back blocks, ready_out must never drop
        write_bits(5 * NC, stalls);
        check("t2_stalls", stalls, 0);
        drain(6 * NC);
        check("t2_dones", dones, 6);
        check("t2_wr_bank", int'(bus.wr_bank), 0);

        // Downstream stalled across three blocks of input
        bus.ready_in = 1'b0;
        write_bits(2 * NC, stalls);
        check("t3_stalls_first_two", stalls, 0);
        check("t3_bank_full", int'(bus.bank_full), 3);
        check("t3_ready_out", int'(bus.ready_out), 0);
        check("t3_valid_out_held", int'(bus.valid_out), 1);
        bus.valid_in = 1'b1;
        repeat (5) step();
        check("t3_wr_addr_stalled", int'(bus.wr_addr), 0);
        check("t3_data_out_index_held", int'(bus.data_out_index), 0);
        bus.ready_in = 1'b1;
        n = 0;
        while (!bus.ready_out && n < 1000) begin
            step();
            n++;
        end
        check("t3_ready_out_return_cycles", n, NC - 1);
        write_bits(NC, stalls);
        drain(9 * NC);
        check("t3_dones", dones, 9);

        // ready_in toggling every cycle while a block is written and read
        fork
            write_bits(NC, stalls4);
            begin
                g = 0;
                while (beats < 10 * NC && g < 3000) begin
                    bus.ready_in = ~bus.ready_in;
                    step();
                    g++;
                end
            end
        join
        bus.ready_in = 1'b1;
        drain(10 * NC);
        check("t4_dones", dones, 10);

        // Asynchronous reset in the middle of a block
        write_bits(100, stalls);
        check("t5_wr_addr_pre", int'(bus.wr_addr), 100);
        #3;
        resetN = 1'b0;
        #1;
        check_reset_values("t5");
        exp_wr_count = 0;
        exp_wr_bank  = 1'b0;
        blocks_since_reset = 0;
        check("t5_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        write_bits(NC, stalls);
        drain(11 * NC);
        check("t5_dones", dones, 11);

`ifdef INTLV_FLUSH_EN
        // Abort a partial write block with the reader idle
        write_bits(50, stalls);
        check("fl_wr_addr_pre", int'(bus.wr_addr), 50);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_wr_addr", int'(bus.wr_addr), 0);
        check("fl_bank_full", int'(bus.bank_full), 0);
        check("fl_wr_bank", int'(bus.wr_bank), int'(exp_wr_bank));
        check("fl_valid_out", int'(bus.valid_out), 0);
        exp_wr_count = exp_wr_count - 50;
        repeat (3) step();
        check("fl_no_done", dones, 11);
        write_bits(NC, stalls);
        drain(12 * NC);
        check("fl_dones", dones, 12);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
